// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the multi-core data-memory arbiter: core count,
// FSM state encoding and a one-hot to index helper.
package mem_arbiter_pkg;

  localparam int NUM_CORES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// Round-robin priority encoder: first eligible core at or above ptr,
// wrapping from core 3 back to core 0.
module rr_select (
  input  logic [3:0] eligible,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic       valid
);

  logic [1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!valid && eligible[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates four cores onto one shared data memory during a matrix-multiply
// run, tracking per-core completion and returning read data one cycle later.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | cores enabled, round-robin grants issued
// DONE  | every core reported end_process, waiting for the next start
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_CORES = mem_arbiter_pkg::NUM_CORES
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES-1:0]          wr,
  input  logic [NUM_CORES*DATA_W-1:0]   addr,
  input  logic [NUM_CORES*DATA_W-1:0]   wdata,
  input  logic [NUM_CORES-1:0]          end_process,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [DATA_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_wr,
  output logic [NUM_CORES-1:0]          gnt,
  output logic [NUM_CORES-1:0]          rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic [NUM_CORES-1:0]          core_en,
  output logic                          all_done,
  output logic                          busy
);

  state_t               state_q, state_d;
  logic [1:0]           ptr_q;
  logic [NUM_CORES-1:0] done_mask_q;
  logic [NUM_CORES-1:0] done_mask_nxt;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] rr_grant;
  logic                 rr_valid;
  logic [1:0]           sel_idx;

  assign done_mask_nxt = done_mask_q | end_process;

  // end_process masks a same-cycle request so a finishing core is never granted
  assign eligible = (state_q == RUN) ? (req & ~done_mask_q & ~end_process) : '0;

  rr_select u_rr_select (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (rr_grant),
    .valid    (rr_valid)
  );

  assign sel_idx = onehot_to_idx(rr_grant);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (done_mask_nxt == '1) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      done_mask_q <= '0;
      gnt         <= '0;
      rvalid      <= '0;
      core_en     <= '0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      gnt       <= rr_grant;
      mem_wr    <= rr_valid & wr[sel_idx];
      mem_addr  <= rr_valid ? addr[int'(sel_idx)*DATA_W +: DATA_W]  : '0;
      mem_wdata <= rr_valid ? wdata[int'(sel_idx)*DATA_W +: DATA_W] : '0;
      // not gated by state, so a read granted in the final RUN cycle still returns in DONE
      rvalid    <= gnt & {NUM_CORES{~mem_wr}};
      if (rr_valid) ptr_q <= sel_idx + 2'd1;

      if (state_q != RUN && state_d == RUN) begin
        done_mask_q <= '0;
        core_en     <= '1;
      end else if (state_q == RUN) begin
        done_mask_q <= done_mask_nxt;
        core_en     <= (state_d == RUN) ? ~done_mask_nxt : '0;
      end else begin
        core_en     <= '0;
      end
    end
  end

  assign rdata    = mem_rdata;
  assign busy     = (state_q == RUN);
  assign all_done = (state_q == DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: run start, round-robin reads,
// a write, early core completion, DONE entry/restart and mid-run reset.
module tb_mem_arbiter;

  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    req = '0;
  logic [3:0]    wr = '0;
  logic [4*DW-1:0] addr = '0;
  logic [4*DW-1:0] wdata = '0;
  logic [3:0]    end_process = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mem_addr, mem_wdata, rdata;
  logic          mem_wr, all_done, busy;
  logic [3:0]    gnt, rvalid, core_en;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.DATA_W(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .req         (req),
    .wr          (wr),
    .addr        (addr),
    .wdata       (wdata),
    .end_process (end_process),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wr      (mem_wr),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .core_en     (core_en),
    .all_done    (all_done),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_rr  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] exp_sk  [4] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    for (int i = 0; i < 4; i++) addr[i*DW +: DW] = 16'h0100 + 16'(i);

    // reset state
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_all_done", all_done, 0);
    check("rst_gnt", gnt, 0);
    check("rst_core_en", core_en, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rvalid", rvalid, 0);

    // start -> RUN
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_core_en", core_en, 4'b1111);
    check("start_gnt", gnt, 0);

    // all four cores reading: round-robin order, rvalid one cycle behind
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      mem_rdata = 16'hA000 + 16'(k);
      step();
      check("rr_gnt", gnt, exp_rr[k]);
      check("rr_mem_wr", mem_wr, 0);
      if (k > 0) begin
        check("rr_rvalid", rvalid, exp_rr[k-1]);
        check("rr_rdata", rdata, 16'hA000 + 16'(k));
      end else begin
        check("rr_rvalid0", rvalid, 0);
      end
    end
    check("rr_addr_core0", mem_addr, 16'h0100);
    req = 4'b0000;
    step();
    check("rr_idle_gnt", gnt, 0);
    check("rr_last_rvalid", rvalid, 4'b0001);
    step();
    check("rr_rvalid_clear", rvalid, 0);

    // core 2 write
    req = 4'b0100;
    wr  = 4'b0100;
    addr[2*DW +: DW]  = 16'h0010;
    wdata[2*DW +: DW] = 16'h00AB;
    step();
    check("wr_gnt", gnt, 4'b0100);
    check("wr_mem_wr", mem_wr, 1);
    check("wr_mem_addr", mem_addr, 16'h0010);
    check("wr_mem_wdata", mem_wdata, 16'h00AB);
    check("wr_rvalid", rvalid, 0);
    req = 4'b0000;
    wr  = 4'b0000;
    addr[2*DW +: DW] = 16'h0102;
    step();
    check("wr_after_gnt", gnt, 0);
    check("wr_after_mem_wr", mem_wr, 0);
    check("wr_after_rvalid", rvalid, 0);

    // end_process[1] with req[1]: core 1 skipped now and afterwards (ptr is 3)
    req = 4'b1111;
    end_process = 4'b0010;
    step();
    end_process = 4'b0000;
    check("ep1_gnt", gnt, 4'b1000);
    check("ep1_core_en", core_en, 4'b1101);
    for (int k = 0; k < 4; k++) begin
      step();
      check("ep1_skip_gnt", gnt, exp_sk[k]);
    end
    check("ep1_core_en_hold", core_en, 4'b1101);

    // last read granted in final RUN cycle, then remaining cores finish
    req = 4'b0001;
    end_process = 4'b1100;
    step();
    check("fin_gnt", gnt, 4'b0001);
    check("fin_core_en", core_en, 4'b0001);
    check("fin_busy", busy, 1);
    req = 4'b0000;
    end_process = 4'b0001;
    step();
    end_process = 4'b0000;
    check("done_all_done", all_done, 1);
    check("done_busy", busy, 0);
    check("done_gnt", gnt, 0);
    check("done_core_en", core_en, 0);
    check("done_late_rvalid", rvalid, 4'b0001);
    step();
    check("done_rvalid_clear", rvalid, 0);
    check("done_hold", all_done, 1);

    // restart clears done_mask: core 1 grantable again; start in RUN ignored
    start = 1'b1;
    step();
    start = 1'b0;
    check("rerun_busy", busy, 1);
    check("rerun_all_done", all_done, 0);
    check("rerun_core_en", core_en, 4'b1111);
    req = 4'b0010;
    start = 1'b1;
    step();
    start = 1'b0;
    check("rerun_gnt_core1", gnt, 4'b0010);
    check("rerun_addr_core1", mem_addr, 16'h0101);
    check("run_start_ignored", busy, 1);

    // reset between edges mid-RUN
    #2 reset = 1'b1;
    #1;
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_core_en", core_en, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_mem_wr", mem_wr, 0);
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_all_done", all_done, 0);
    #2 reset = 1'b0;
    step();
    check("post_rst_rvalid", rvalid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_gnt", gnt, 0);
    check("post_rst_core_en", core_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
